// File: rtl/spi_sram_wrbuf_if.sv
// Bundle between the SPI bridge / chipset arbiter / SRAM pins and the write buffer.
// master: environment side (bridge strobes, arbiter grant, SRAM read data).
// slave : write buffer side (bus request, SRAM control/address/data, status flags).
interface spi_sram_wrbuf_if;
   // bridge write strobes and bus ownership
   logic        in_hwr;
   logic        in_lwr;
   logic [22:0] in_addr;
   logic [15:0] in_data;
   logic        bus_req;
   logic        bus_ack;
   logic        clr_err;
   logic        mem_req;
   // asynchronous SRAM pins
   logic [22:0] ram_addr;
   logic [15:0] ram_dout;
   logic [15:0] ram_din;
   logic        ram_we_n;
   logic        ram_oe_n;
   logic        ram_bhe_n;
   logic        ram_ble_n;
   // status
   logic        busy;
   logic        overflow;
   logic        verify_err;

   modport master (
      output in_hwr, in_lwr, in_addr, in_data, bus_req, bus_ack, clr_err, ram_din,
      input  mem_req, ram_addr, ram_dout, ram_we_n, ram_oe_n, ram_bhe_n, ram_ble_n,
             busy, overflow, verify_err
   );

   modport slave (
      input  in_hwr, in_lwr, in_addr, in_data, bus_req, bus_ack, clr_err, ram_din,
      output mem_req, ram_addr, ram_dout, ram_we_n, ram_oe_n, ram_bhe_n, ram_ble_n,
             busy, overflow, verify_err
   );
endinterface

// File: rtl/spi_sram_wrbuf.sv
// Write buffer: queues single-cycle bridge write strobes and replays each as a timed
// async SRAM write (SETUP/STROBE/HOLD) while the arbiter grants the bus.
// Ports: clk, rst (async active-high), bus (spi_sram_wrbuf_if.slave).
// Optional readback check after each write: define SPI_SRAM_WRBUF_VERIFY_EN.
module spi_sram_wrbuf #(
   parameter int DEPTH_LOG2 = 3,
   parameter int T_SETUP    = 1,
   parameter int T_PULSE    = 2,
   parameter int T_HOLD     = 1
) (
   input logic             clk,
   input logic             rst,
   spi_sram_wrbuf_if.slave bus
);
   localparam int DEPTH = 2 ** DEPTH_LOG2;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] SETUP  = 3'd1;
   localparam logic [2:0] STROBE = 3'd2;
   localparam logic [2:0] HOLD   = 3'd3;
`ifdef SPI_SRAM_WRBUF_VERIFY_EN
   localparam logic [2:0] VERIFY = 3'd4;
`endif

   typedef struct packed {
      logic [22:0] addr;
      logic [15:0] data;
      logic        hwr;
      logic        lwr;
   } entry_t;

   entry_t              fifo_mem [DEPTH];
   entry_t              head;
   logic [DEPTH_LOG2:0] wr_ptr, rd_ptr, rd_next;
   logic                empty, full, push, pop, push_ok, more;
   logic [2:0]          state, state_next;
   logic [7:0]          cnt, cnt_load;
   logic                verr_evt;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                    (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
   assign push    = bus.in_hwr | bus.in_lwr;
   // a pop on the same edge frees the slot, so a push into a full FIFO still lands
   assign push_ok = push & (~full | pop);
   assign rd_next = rd_ptr + {{DEPTH_LOG2{1'b0}}, pop};
   // entries left once the current head retires; a same-edge push is not yet readable
   assign more    = (wr_ptr != (rd_ptr + {{DEPTH_LOG2{1'b0}}, 1'b1}));
   // entry that becomes the head after this edge
   assign head    = fifo_mem[rd_next[DEPTH_LOG2-1:0]];
   assign bus.busy = ~empty | (state != IDLE);

   always_comb begin
      state_next = state;
      pop        = 1'b0;
      verr_evt   = 1'b0;
      case (state)
         IDLE:   if (!empty && bus.bus_ack) state_next = SETUP;
         SETUP:  if (cnt == 8'd0) state_next = STROBE;
         STROBE: if (cnt == 8'd0) state_next = HOLD;
         HOLD: begin
            if (cnt == 8'd0) begin
`ifdef SPI_SRAM_WRBUF_VERIFY_EN
               state_next = VERIFY;
`else
               pop        = 1'b1;
               state_next = (more && bus.bus_ack) ? SETUP : IDLE;
`endif
            end
         end
`ifdef SPI_SRAM_WRBUF_VERIFY_EN
         VERIFY: begin
            if (cnt == 8'd0) begin
               pop        = 1'b1;
               // only lanes that were written are meaningful on readback
               verr_evt   = (!bus.ram_bhe_n && (bus.ram_din[15:8] != bus.ram_dout[15:8])) ||
                            (!bus.ram_ble_n && (bus.ram_din[7:0]  != bus.ram_dout[7:0]));
               state_next = (more && bus.bus_ack) ? SETUP : IDLE;
            end
         end
`endif
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      cnt_load = 8'd0;
      case (state_next)
         SETUP:  cnt_load = 8'(T_SETUP - 1);
         STROBE: cnt_load = 8'(T_PULSE - 1);
         HOLD:   cnt_load = 8'(T_HOLD - 1);
`ifdef SPI_SRAM_WRBUF_VERIFY_EN
         VERIFY: cnt_load = 8'(T_PULSE - 1);
`endif
         default: cnt_load = 8'd0;
      endcase
   end

   // storage has no reset; validity is tracked entirely by the pointers
   always_ff @(posedge clk) begin
      if (push_ok)
         fifo_mem[wr_ptr[DEPTH_LOG2-1:0]] <= {bus.in_addr, bus.in_data, bus.in_hwr, bus.in_lwr};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= 8'd0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         bus.mem_req   <= 1'b0;
         bus.overflow  <= 1'b0;
         bus.ram_we_n  <= 1'b1;
         bus.ram_bhe_n <= 1'b1;
         bus.ram_ble_n <= 1'b1;
         bus.ram_addr  <= '0;
         bus.ram_dout  <= '0;
      end else begin
         state <= state_next;
         // every state change reloads; HOLD->SETUP is a change, so back-to-back works
         if (state_next != state)
            cnt <= cnt_load;
         else if (cnt != 8'd0)
            cnt <= cnt - 8'd1;
         if (push_ok)
            wr_ptr <= wr_ptr + {{DEPTH_LOG2{1'b0}}, 1'b1};
         rd_ptr       <= rd_next;
         bus.mem_req  <= bus.bus_req | ~empty;
         // a new overflow beats a simultaneous clear
         bus.overflow <= (push & full & ~pop) | (bus.overflow & ~bus.clr_err);
         // SRAM controls are registered from the next state so they change with it
         bus.ram_we_n <= (state_next != STROBE);
         if (state_next == SETUP && state != SETUP) begin
            bus.ram_addr  <= head.addr;
            bus.ram_dout  <= head.data;
            bus.ram_bhe_n <= ~head.hwr;
            bus.ram_ble_n <= ~head.lwr;
         end else if (state_next == IDLE && state != IDLE) begin
            bus.ram_bhe_n <= 1'b1;
            bus.ram_ble_n <= 1'b1;
         end
      end
   end

`ifdef SPI_SRAM_WRBUF_VERIFY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.ram_oe_n   <= 1'b1;
         bus.verify_err <= 1'b0;
      end else begin
         bus.ram_oe_n   <= (state_next != VERIFY);
         bus.verify_err <= verr_evt | (bus.verify_err & ~bus.clr_err);
      end
   end
`else
   assign bus.ram_oe_n   = 1'b1;
   assign bus.verify_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_sram_wrbuf.sv
// Directed bench for spi_sram_wrbuf: reset, single write timing, overflow and
// FIFO order, grant loss mid-cycle, byte-lane select, async reset mid-strobe,
// and (with SPI_SRAM_WRBUF_VERIFY_EN) readback checking.
module tb_spi_sram_wrbuf;
   logic        clk = 1'b0;
   logic        rst;
   int          vectors = 0;
   int          miscompares = 0;
   logic        din_force;
   logic [15:0] din_val;

`ifdef SPI_SRAM_WRBUF_VERIFY_EN
   localparam int WLEN = 6;
`else
   localparam int WLEN = 4;
`endif

   spi_sram_wrbuf_if ifc();

   // SRAM model: reads back what was written unless a corrupt value is forced
   assign ifc.ram_din = din_force ? din_val : ifc.ram_dout;

   spi_sram_wrbuf #(.DEPTH_LOG2(3), .T_SETUP(1), .T_PULSE(2), .T_HOLD(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   always #5 clk = ~clk;

   // drive one strobe across the next rising edge; returns at the following negedge
   task automatic strobe(input logic h, input logic l, input logic [22:0] a, input logic [15:0] d);
      ifc.in_hwr  = h;
      ifc.in_lwr  = l;
      ifc.in_addr = a;
      ifc.in_data = d;
      @(negedge clk);
      ifc.in_hwr  = 1'b0;
      ifc.in_lwr  = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if ({ifc.ram_we_n, ifc.ram_oe_n, ifc.ram_bhe_n, ifc.ram_ble_n} !== 4'hF) begin
         miscompares++;
         $display("FAIL reset_ctl: got %b expected 1111",
                  {ifc.ram_we_n, ifc.ram_oe_n, ifc.ram_bhe_n, ifc.ram_ble_n});
      end
      vectors++;
      if ({ifc.mem_req, ifc.busy, ifc.overflow, ifc.verify_err} !== 4'h0) begin
         miscompares++;
         $display("FAIL reset_flags: got %b expected 0000",
                  {ifc.mem_req, ifc.busy, ifc.overflow, ifc.verify_err});
      end
      vectors++;
      if (ifc.ram_addr !== 23'h0 || ifc.ram_dout !== 16'h0) begin
         miscompares++;
         $display("FAIL reset_addr_data: got %h/%h expected 0/0", ifc.ram_addr, ifc.ram_dout);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single_write;
      ifc.bus_ack = 1'b1;
      strobe(1'b1, 1'b1, 23'h000080, 16'hBEEF);          // edge N
      vectors++;
      if (ifc.busy !== 1'b1) begin
         miscompares++; $display("FAIL single_busy_after_push: got %b expected 1", ifc.busy);
      end
      @(negedge clk);                                     // N+1: SETUP
      vectors++;
      if ({ifc.ram_we_n, ifc.ram_bhe_n, ifc.ram_ble_n} !== 3'b100 ||
          ifc.ram_addr !== 23'h000080 || ifc.ram_dout !== 16'hBEEF) begin
         miscompares++;
         $display("FAIL single_setup: we/bhe/ble=%b addr=%h dout=%h expected 100 000080 beef",
                  {ifc.ram_we_n, ifc.ram_bhe_n, ifc.ram_ble_n}, ifc.ram_addr, ifc.ram_dout);
      end
      @(negedge clk);                                     // N+2
      vectors++;
      if (ifc.ram_we_n !== 1'b0) begin
         miscompares++; $display("FAIL single_strobe1: we_n=%b expected 0", ifc.ram_we_n);
      end
      @(negedge clk);                                     // N+3
      vectors++;
      if (ifc.ram_we_n !== 1'b0) begin
         miscompares++; $display("FAIL single_strobe2: we_n=%b expected 0", ifc.ram_we_n);
      end
      @(negedge clk);                                     // N+4: HOLD
      vectors++;
      if (ifc.ram_we_n !== 1'b1 || ifc.busy !== 1'b1) begin
         miscompares++;
         $display("FAIL single_hold: we_n=%b busy=%b expected 1 1", ifc.ram_we_n, ifc.busy);
      end
      repeat (WLEN - 3) @(negedge clk);                   // first IDLE cycle
      vectors++;
      if (ifc.busy !== 1'b0 || {ifc.ram_bhe_n, ifc.ram_ble_n} !== 2'b11) begin
         miscompares++;
         $display("FAIL single_done: busy=%b bhe/ble=%b expected 0 11",
                  ifc.busy, {ifc.ram_bhe_n, ifc.ram_ble_n});
      end
   endtask

   task automatic test_overflow;
      logic [15:0] wdat [16];
      int          wcyc [16];
      int          nwr = 0;
      int          busy_cnt = 0;
      logic        prev_we = 1'b1;
      ifc.bus_ack = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         ifc.in_hwr  = 1'b1;
         ifc.in_lwr  = 1'b1;
         ifc.in_addr = 23'(i);
         ifc.in_data = 16'(i);
         @(negedge clk);
         if (i == 8) begin
            vectors++;
            if (ifc.overflow !== 1'b0) begin
               miscompares++; $display("FAIL ovf_at_8: got %b expected 0", ifc.overflow);
            end
         end
      end
      ifc.in_hwr = 1'b0;
      ifc.in_lwr = 1'b0;
      vectors++;
      if (ifc.overflow !== 1'b1 || ifc.ram_we_n !== 1'b1) begin
         miscompares++;
         $display("FAIL ovf_at_9: overflow=%b we_n=%b expected 1 1", ifc.overflow, ifc.ram_we_n);
      end
      @(negedge clk);
      vectors++;
      if (ifc.mem_req !== 1'b1) begin
         miscompares++; $display("FAIL ovf_mem_req: got %b expected 1", ifc.mem_req);
      end
      ifc.bus_ack = 1'b1;
      for (int c = 1; c <= 8 * WLEN + 8; c++) begin
         @(negedge clk);
         if (ifc.busy === 1'b1) busy_cnt++;
         if (ifc.ram_we_n === 1'b0 && prev_we === 1'b1 && nwr < 16) begin
            wdat[nwr] = ifc.ram_dout;
            wcyc[nwr] = c;
            nwr++;
         end
         prev_we = ifc.ram_we_n;
      end
      vectors++;
      if (nwr !== 8) begin
         miscompares++; $display("FAIL ovf_write_count: got %0d expected 8", nwr);
      end
      for (int k = 0; k < 8 && k < nwr; k++) begin
         vectors++;
         if (wdat[k] !== 16'(k + 1)) begin
            miscompares++; $display("FAIL ovf_order[%0d]: got %h expected %h", k, wdat[k], 16'(k + 1));
         end
         if (k > 0) begin
            vectors++;
            if (wcyc[k] - wcyc[k-1] !== WLEN) begin
               miscompares++;
               $display("FAIL ovf_spacing[%0d]: got %0d expected %0d", k, wcyc[k] - wcyc[k-1], WLEN);
            end
         end
      end
      vectors++;
      if (busy_cnt !== 8 * WLEN) begin
         miscompares++; $display("FAIL ovf_total_cycles: got %0d expected %0d", busy_cnt, 8 * WLEN);
      end
      vectors++;
      if (ifc.overflow !== 1'b1) begin
         miscompares++; $display("FAIL ovf_sticky: got %b expected 1", ifc.overflow);
      end
      ifc.clr_err = 1'b1;
      @(negedge clk);
      ifc.clr_err = 1'b0;
      vectors++;
      if (ifc.overflow !== 1'b0) begin
         miscompares++; $display("FAIL ovf_clear: got %b expected 0", ifc.overflow);
      end
   endtask

   task automatic test_grant_loss;
      logic bad = 1'b0;
      logic done = 1'b0;
      ifc.bus_ack = 1'b1;
      ifc.in_hwr  = 1'b1;
      ifc.in_lwr  = 1'b1;
      ifc.in_addr = 23'h000100;
      ifc.in_data = 16'hA5A5;
      @(negedge clk);                                     // edge N
      strobe(1'b1, 1'b1, 23'h000101, 16'h5A5A);           // edge N+1: A in SETUP
      @(negedge clk);                                     // N+2: A in STROBE
      vectors++;
      if (ifc.ram_we_n !== 1'b0 || ifc.ram_dout !== 16'hA5A5) begin
         miscompares++;
         $display("FAIL grant_first_strobe: we_n=%b dout=%h expected 0 a5a5", ifc.ram_we_n, ifc.ram_dout);
      end
      ifc.bus_ack = 1'b0;
      @(negedge clk);                                     // N+3
      vectors++;
      if (ifc.ram_we_n !== 1'b0 || ifc.ram_addr !== 23'h000100) begin
         miscompares++;
         $display("FAIL grant_strobe_kept: we_n=%b addr=%h expected 0 000100", ifc.ram_we_n, ifc.ram_addr);
      end
      @(negedge clk);                                     // N+4: HOLD
      vectors++;
      if (ifc.ram_we_n !== 1'b1) begin
         miscompares++; $display("FAIL grant_hold: we_n=%b expected 1", ifc.ram_we_n);
      end
      repeat (WLEN - 3) @(negedge clk);                   // IDLE, waiting for grant
      vectors++;
      if ({ifc.ram_bhe_n, ifc.ram_ble_n} !== 2'b11 || ifc.busy !== 1'b1) begin
         miscompares++;
         $display("FAIL grant_idle: bhe/ble=%b busy=%b expected 11 1",
                  {ifc.ram_bhe_n, ifc.ram_ble_n}, ifc.busy);
      end
      repeat (3) begin
         @(negedge clk);
         if (ifc.ram_we_n !== 1'b1 || ifc.ram_bhe_n !== 1'b1) bad = 1'b1;
      end
      vectors++;
      if (bad !== 1'b0) begin
         miscompares++; $display("FAIL grant_wait: cycle started without grant, got 1 expected 0");
      end
      ifc.bus_ack = 1'b1;
      @(negedge clk);
      vectors++;
      if (ifc.ram_addr !== 23'h000101 || ifc.ram_bhe_n !== 1'b0 || ifc.ram_we_n !== 1'b1) begin
         miscompares++;
         $display("FAIL grant_second_setup: addr=%h bhe_n=%b we_n=%b expected 000101 0 1",
                  ifc.ram_addr, ifc.ram_bhe_n, ifc.ram_we_n);
      end
      @(negedge clk);
      vectors++;
      if (ifc.ram_we_n !== 1'b0 || ifc.ram_dout !== 16'h5A5A) begin
         miscompares++;
         $display("FAIL grant_second_strobe: we_n=%b dout=%h expected 0 5a5a", ifc.ram_we_n, ifc.ram_dout);
      end
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk);
         if (ifc.busy === 1'b0) done = 1'b1;
      end
      vectors++;
      if (done !== 1'b1) begin
         miscompares++; $display("FAIL grant_drain: busy still %b expected 0", ifc.busy);
      end
   endtask

   task automatic test_lane_select;
      logic [1:0] exp_be;
      logic       done = 1'b0;
      ifc.bus_ack = 1'b1;
      ifc.in_hwr  = 1'b0;
      ifc.in_lwr  = 1'b1;
      ifc.in_addr = 23'h000200;
      ifc.in_data = 16'h12AB;
      @(negedge clk);                                     // edge N
      strobe(1'b1, 1'b0, 23'h000201, 16'h3400);           // N+1: first SETUP
      for (int k = 1; k <= 2 * WLEN; k++) begin
         if (k > 1) @(negedge clk);
         exp_be = (k <= WLEN) ? 2'b10 : 2'b01;
         vectors++;
         if ({ifc.ram_bhe_n, ifc.ram_ble_n} !== exp_be) begin
            miscompares++;
            $display("FAIL lane_be[%0d]: bhe/ble=%b expected %b", k, {ifc.ram_bhe_n, ifc.ram_ble_n}, exp_be);
         end
         if (k == 1 || k == WLEN + 1) begin
            vectors++;
            if (ifc.ram_dout !== ((k == 1) ? 16'h12AB : 16'h3400)) begin
               miscompares++;
               $display("FAIL lane_data[%0d]: got %h expected %h", k, ifc.ram_dout,
                        (k == 1) ? 16'h12AB : 16'h3400);
            end
         end
      end
      for (int c = 0; c < 10 && !done; c++) begin
         @(negedge clk);
         if (ifc.busy === 1'b0) done = 1'b1;
      end
      vectors++;
      if (done !== 1'b1) begin
         miscompares++; $display("FAIL lane_drain: busy still %b expected 0", ifc.busy);
      end
   endtask

   task automatic test_async_reset;
      logic seen = 1'b0;
      logic bad = 1'b0;
      ifc.bus_ack = 1'b0;
      for (int i = 0; i < 9; i++) begin
         ifc.in_hwr  = 1'b1;
         ifc.in_lwr  = 1'b1;
         ifc.in_addr = 23'(16'h400 + i);
         ifc.in_data = 16'(16'hC000 + i);
         @(negedge clk);
      end
      ifc.in_hwr  = 1'b0;
      ifc.in_lwr  = 1'b0;
      ifc.bus_ack = 1'b1;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (ifc.ram_we_n === 1'b0) seen = 1'b1;
      end
      vectors++;
      if (seen !== 1'b1 || ifc.overflow !== 1'b1) begin
         miscompares++;
         $display("FAIL arst_setup: strobe_seen=%b overflow=%b expected 1 1", seen, ifc.overflow);
      end
      #2 rst = 1'b1;                                      // between clock edges
      #1;
      vectors++;
      if ({ifc.ram_we_n, ifc.ram_bhe_n, ifc.ram_ble_n} !== 3'b111) begin
         miscompares++;
         $display("FAIL arst_pins: we/bhe/ble=%b expected 111", {ifc.ram_we_n, ifc.ram_bhe_n, ifc.ram_ble_n});
      end
      vectors++;
      if (ifc.overflow !== 1'b0 || ifc.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL arst_state: overflow=%b busy=%b expected 0 0", ifc.overflow, ifc.busy);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (ifc.ram_we_n !== 1'b1 || ifc.busy !== 1'b0 || ifc.mem_req !== 1'b0) bad = 1'b1;
      end
      vectors++;
      if (bad !== 1'b0) begin
         miscompares++; $display("FAIL arst_no_write: activity after reset got 1 expected 0");
      end
   endtask

`ifdef SPI_SRAM_WRBUF_VERIFY_EN
   task automatic test_verify;
      ifc.bus_ack = 1'b1;
      din_force   = 1'b1;
      din_val     = 16'hBEEE;
      strobe(1'b1, 1'b1, 23'h000300, 16'hBEEF);
      repeat (WLEN + 1) @(negedge clk);
      vectors++;
      if (ifc.verify_err !== 1'b1) begin
         miscompares++; $display("FAIL verify_mismatch: got %b expected 1", ifc.verify_err);
      end
      ifc.clr_err = 1'b1;
      @(negedge clk);
      ifc.clr_err = 1'b0;
      vectors++;
      if (ifc.verify_err !== 1'b0) begin
         miscompares++; $display("FAIL verify_clear: got %b expected 0", ifc.verify_err);
      end
      din_val = 16'h00EF;
      strobe(1'b0, 1'b1, 23'h000301, 16'hBEEF);
      repeat (WLEN + 1) @(negedge clk);
      vectors++;
      if (ifc.verify_err !== 1'b0) begin
         miscompares++; $display("FAIL verify_low_lane: got %b expected 0", ifc.verify_err);
      end
      din_force = 1'b0;
   endtask
`endif

   initial begin
      rst         = 1'b1;
      din_force   = 1'b0;
      din_val     = 16'h0;
      ifc.in_hwr  = 1'b0;
      ifc.in_lwr  = 1'b0;
      ifc.in_addr = 23'h0;
      ifc.in_data = 16'h0;
      ifc.bus_req = 1'b0;
      ifc.bus_ack = 1'b0;
      ifc.clr_err = 1'b0;
      test_reset();
      test_single_write();
      test_overflow();
      test_grant_loss();
      test_lane_select();
`ifdef SPI_SRAM_WRBUF_VERIFY_EN
      test_verify();
`endif
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/spi_sram_wrbuf.md
Name: spi_sram_wrbuf

Overview:
- Downstream of the SPI-to-SRAM bridge.
- Absorbs its single-cycle write strobes (hwr/lwr, addr[23:1], data[15:0]) into a small FIFO.
- Replays each entry as a properly timed asynchronous SRAM write cycle, but only while the chipset arbiter grants the bus.
- Decouples SPI burst rate from SRAM/bus timing and reports overflow.

Parameters:
- DEPTH_LOG2, 3, FIFO depth = 2**DEPTH_LOG2 entries (default 8).
- T_SETUP, 1, cycles address/data/byte-enables stable before we_n falls (>=1).
- T_PULSE, 2, cycles we_n held low (>=1).
- T_HOLD, 1, cycles address/data held after we_n rises (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- in_hwr  in  1  high-byte write strobe from bridge, single-cycle.
- in_lwr  in  1  low-byte write strobe from bridge, single-cycle.
- in_addr  in  23  word address [23:1], valid with either strobe.
- in_data  in  16  write data, valid with either strobe.
- bus_req  in  1  bridge owns/holds the bus for an SPI transfer.
- bus_ack  in  1  arbiter grant; a cycle may only start while high.
- clr_err  in  1  synchronous clear of sticky flags.
- mem_req  out  1  bus request to arbiter.
- ram_addr  out  23  SRAM word address.
- ram_dout  out  16  SRAM write data.
- ram_din  in  16  SRAM read data (used only with the optional feature).
- ram_we_n  out  1  write enable, active-low.
- ram_oe_n  out  1  output enable, active-low.
- ram_bhe_n  out  1  high byte enable, active-low.
- ram_ble_n  out  1  low byte enable, active-low.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- overflow  out  1  sticky: a strobe arrived while the FIFO was full.
- verify_err  out  1  sticky readback mismatch (optional feature).

Behaviour:
- Reset values (asynchronous assert, all outputs at once):
  - ram_we_n, ram_oe_n, ram_bhe_n, ram_ble_n = 1.
  - ram_addr = 0, ram_dout = 0.
  - mem_req, busy, overflow, verify_err = 0.
  - FIFO empty; FSM = IDLE.
- Push:
  - Any cycle with in_hwr|in_lwr stores {addr, data, hwr, lwr} at the write pointer on that edge.
  - If the FIFO is full, the entry is dropped and overflow is set; the existing contents are untouched.
- Pointers: DEPTH_LOG2+1 bits, wrap naturally; full/empty decided by pointer compare.
- Simultaneous push and pop are legal, including when full: a pop in the same cycle frees the slot, so the push succeeds.
- mem_req = bus_req | ~empty, registered.
- FSM states: IDLE, SETUP, STROBE, HOLD (plus VERIFY when the feature is compiled in).
- IDLE -> SETUP when ~empty & bus_ack. On entry, latch the head entry onto ram_addr/ram_dout and drive bhe_n = ~hwr, ble_n = ~lwr.
- SETUP: we_n = 1 for T_SETUP cycles, then -> STROBE.
- STROBE: we_n = 0 for T_PULSE cycles, then -> HOLD.
- HOLD: we_n = 1 for T_HOLD cycles. On the last cycle, pop the head.
- Exit from HOLD:
  - -> SETUP directly if the FIFO is still non-empty and bus_ack = 1 (no idle gap).
  - Otherwise -> IDLE with byte enables deasserted.
- Latency: strobe at edge N -> SETUP from edge N+1 (bus_ack already high) -> we_n low on cycles N+2..N+1+T_PULSE.
- A started cycle always completes, even if bus_ack falls mid-cycle. The next cycle waits for bus_ack.
- A single cycle counter is loaded on each state entry and counts down to 0; the state exits when it reaches 0.
- clr_err clears overflow/verify_err. If a new error event occurs in the same cycle, the error wins.
- Entries are written in FIFO order; no coalescing.

Optional Feature:
- Macro: SPI_SRAM_WRBUF_VERIFY_EN.
- Defined:
  - HOLD -> VERIFY instead of the direct exit.
  - VERIFY: oe_n = 0 and we_n = 1 for T_PULSE cycles, same address and byte enables; the head is popped on VERIFY exit, not HOLD.
  - ram_din is sampled on the last VERIFY cycle; only enabled lanes are compared.
  - A mismatch sets verify_err.
  - Per-write length = T_SETUP + T_PULSE + T_HOLD + T_PULSE.
- Undefined: no VERIFY state; ram_oe_n constant 1; verify_err constant 0.

Test Plan:
- Single write, bus_ack=1: hwr=lwr=1, addr 0x000080, data 0xBEEF at edge 10 -> SETUP from edge 11; we_n low on cycles 12-13; bhe_n=ble_n=0, ram_addr=0x000080, ram_dout=0xBEEF; busy falls after cycle 14.
- Overflow: bus_ack=0, 9 consecutive strobes with data 0x0001..0x0009 -> overflow=1 after 9th, mem_req=1. Raise bus_ack -> exactly 8 writes, data 0x0001..0x0008 in order, back-to-back every 4 cycles, 32 cycles total.
- Grant loss: deassert bus_ack during STROBE of first of 2 entries -> first cycle completes unchanged; second starts only 1 cycle after bus_ack returns.
- Lane select: lwr only, data 0x12AB -> ble_n=0, bhe_n=1 throughout the cycle; then hwr only -> bhe_n=0, ble_n=1.
- Async reset mid-STROBE -> we_n=1 and byte enables=1 immediately (no clock edge); FIFO empty, overflow=0. No write issued after rst release.
- (VERIFY_EN) ram_din forced to 0xBEEE for a 0xBEEF write -> verify_err=1. With only lwr enabled and ram_din=0x00EF -> no error. clr_err -> verify_err=0.
